decode_issue_queue: RTL

- Parametrised successor to the combinational ID-stage control decoder in the MIPS pipeline.
- Adds a DEPTH-entry instruction queue between IF and ID.
- Decodes the queue head into a registered control/exception bundle.
- Tracks branch delay slots internally and supports valid/ready back-pressure and synchronous flush on exception/eret.

---
 rtl/decode_issue_queue_if.sv | 34 +++
 rtl/decode_issue_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/decode_issue_queue_if.sv
// decode_issue_queue_if: fetch-side, issue-side and flush signals of the decode issue queue
interface decode_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 32
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_pc;
  logic [31:0]             in_instr;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_pc;
  logic [31:0]             out_instr;
  logic                    out_wreg;
  logic                    out_wmem;
  logic                    out_is_branch;
  logic                    out_in_delayslot;
  logic                    out_wcp0;
  logic                    out_rcp0;
  logic [4:0]              out_cp0_addr;
  logic [EXC_W-1:0]        out_exception;
  logic [$clog2(DEPTH):0]  count;
  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_wreg, out_wmem, out_is_branch,
           out_in_delayslot, out_wcp0, out_rcp0, out_cp0_addr, out_exception, count
  );
  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_wreg, out_wmem, out_is_branch,
           out_in_delayslot, out_wcp0, out_rcp0, out_cp0_addr, out_exception, count
  );
endinterface

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: IF->ID instruction FIFO whose head is decoded into a registered control/exception bundle
module decode_issue_queue #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 32
) (
  input logic                clk,
  input logic                rst,
  decode_issue_queue_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             wreg;
    logic             wmem;
    logic             is_branch;
    logic             in_ds;
    logic             wcp0;
    logic             rcp0;
    logic [4:0]       cp0_addr;
    logic [EXC_W-1:0] exc;
  } bundle_t;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ds_q, ds_d, out_valid_q, out_valid_d;
  bundle_t       out_q, out_d;
  logic          in_ready, push, pop;
  logic [31:0]   h_pc, h_instr;
  logic [5:0]    op, fn;
  logic [4:0]    rt;
  logic          r_wreg, r_ok, ri_ok, mtc0, mfc0, eret, op_ok, aerr;
  logic          br, wreg, wmem, wcp0, rcp0;
  logic [4:0]    cp0_addr;
  logic [6:0]    exc7;
  // count can only reach DEPTH (a power of 2) when its MSB is set
  assign in_ready = ~count_q[AW];
  assign push     = io.in_valid & in_ready & ~io.flush;
  assign pop      = (count_q != '0) & (~out_valid_q | io.out_ready);
  assign h_pc     = pc_mem[rd_ptr_q];
  assign h_instr  = instr_mem[rd_ptr_q];
  always_comb begin
    op       = h_instr[31:26];
    rt       = h_instr[20:16];
    fn       = h_instr[5:0];
    r_wreg   = fn inside {[6'd32:6'd39], 6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd9, 6'd16, 6'd18};
    r_ok     = r_wreg | (fn inside {6'd8, [6'd24:6'd27], 6'd17, 6'd19, 6'd12, 6'd13});
    ri_ok    = rt inside {5'd0, 5'd1, 5'd16, 5'd17};
    mtc0     = (h_instr[31:21] == 11'b01000000100) & (h_instr[10:3] == 8'd0);
    mfc0     = (h_instr[31:21] == 11'b01000000000) & (h_instr[10:3] == 8'd0);
    eret     = (op == 6'd16) & (fn == 6'd24);
    op_ok    = ((op == 6'd0) & r_ok) | ((op == 6'd1) & ri_ok) | mtc0 | mfc0 | eret |
               (op inside {[6'd2:6'd15], 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43});
    aerr     = h_pc[1:0] != 2'd0;
    br       = (op inside {[6'd2:6'd7]}) | ((op == 6'd1) & ri_ok) | ((op == 6'd0) & (fn inside {6'd8, 6'd9}));
    wreg     = ~aerr & (((op == 6'd0) & r_wreg & (h_instr != 32'd0)) | mfc0 |
               ((op == 6'd1) & (rt inside {5'd16, 5'd17})) |
               (op inside {[6'd8:6'd15], 6'd3, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37}));
    wmem     = ~aerr & (op inside {6'd40, 6'd41, 6'd43});
    wcp0     = ~aerr & mtc0;
    rcp0     = ~aerr & mfc0;
    cp0_addr = (wcp0 | rcp0) ? h_instr[15:11] : 5'd0;
    exc7     = aerr                          ? 7'h20 :
               !op_ok                        ? 7'h40 :
               (op == 6'd0) & (fn == 6'd12)  ? 7'h01 :
               (op == 6'd0) & (fn == 6'd13)  ? 7'h02 :
               eret                          ? 7'h04 : 7'h00;
  end
  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
    out_valid_d = pop | (out_valid_q & ~io.out_ready);
    ds_d        = pop ? br : ds_q;
    out_d       = pop ? {h_pc, h_instr, wreg, wmem, br, ds_q, wcp0, rcp0, cp0_addr, EXC_W'(exc7)} : out_q;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= io.in_pc;
      instr_mem[wr_ptr_q] <= io.in_instr;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || io.flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ds_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ds_q        <= ds_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else if (!io.flush) out_q <= out_d;
  end
  assign io.in_ready         = in_ready;
  assign io.count            = count_q;
  assign io.out_valid        = out_valid_q;
  assign io.out_pc           = out_q.pc;
  assign io.out_instr        = out_q.instr;
  assign io.out_wreg         = out_q.wreg;
  assign io.out_wmem         = out_q.wmem;
  assign io.out_is_branch    = out_q.is_branch;
  assign io.out_in_delayslot = out_q.in_ds;
  assign io.out_wcp0         = out_q.wcp0;
  assign io.out_rcp0         = out_q.rcp0;
  assign io.out_cp0_addr     = out_q.cp0_addr;
  assign io.out_exception    = out_q.exc;
endmodule
